// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver and make/break decoder driving a two-digit hex display.
// Optional odd-parity rejection is enabled by defining PS2_PARITY_CHECK_EN.
module ps2_key_decoder #(
   parameter int TIMEOUT_CYCLES = 50000,
   parameter int SYNC_STAGES    = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [7:0] scan_code,
   output logic       key_light,
   output logic [7:0] press_count,
   output logic       byte_valid,
   output logic       frame_err
);
   // state  | meaning
   // IDLE   | waiting for a start bit (data low on a falling edge)
   // DATA   | shifting in 8 data bits, LSB first
   // PARITY | latching the parity bit
   // STOP   | checking the stop bit, then accept or reject the frame

   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [7:0] BREAK_CODE = 8'hF0;
   localparam logic [7:0] EXT_CODE   = 8'hE0;

   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

   state_t                 state;
   state_t                 state_nxt;
   logic [SYNC_STAGES-1:0] clk_sync;
   logic [SYNC_STAGES-1:0] data_sync;
   logic                   clk_prev;
   logic                   fall;
   logic                   data_s;
   logic [2:0]             bit_cnt;
   logic [7:0]             shift;
   logic                   par_bit;
   logic [CW-1:0]          idle_cnt;
   logic                   timeout;
   logic                   frame_ok;
   logic                   accept;
   logic                   reject;
   logic                   brk;
   logic                   ext;

   always_ff @(posedge clk) begin
      if (rst) begin
         clk_sync  <= '1;
         data_sync <= '1;
         clk_prev  <= 1'b1;
      end else begin
         clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
         data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
         clk_prev  <= clk_sync[SYNC_STAGES-1];
      end
   end

   assign fall   = clk_prev & ~clk_sync[SYNC_STAGES-1];
   assign data_s = data_sync[SYNC_STAGES-1];

   // Down-counter reloaded on every edge; terminal count lands the error pulse
   // exactly TIMEOUT_CYCLES cycles after the last detected edge.
   assign timeout = (state != IDLE) && !fall && (idle_cnt == CW'(1));

`ifdef PS2_PARITY_CHECK_EN
   assign frame_ok = data_s & (^{shift, par_bit});
`else
   logic unused_parity;
   assign unused_parity = par_bit;
   assign frame_ok      = data_s;
`endif

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (timeout) begin
         state_nxt = IDLE;
      end else if (fall) begin
         case (state)
            IDLE:    if (!data_s) state_nxt = DATA;
            DATA:    if (bit_cnt == 3'd7) state_nxt = PARITY;
            PARITY:  state_nxt = STOP;
            STOP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_comb begin
      accept = 1'b0;
      reject = 1'b0;
      if (state == STOP && fall) begin
         accept = frame_ok;
         reject = !frame_ok;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bit_cnt  <= '0;
         shift    <= '0;
         par_bit  <= 1'b0;
         idle_cnt <= '0;
      end else begin
         if (fall)
            idle_cnt <= CW'(TIMEOUT_CYCLES - 1);
         else if (state == IDLE)
            idle_cnt <= '0;
         else if (idle_cnt != '0)
            idle_cnt <= idle_cnt - CW'(1);

         if (timeout) begin
            bit_cnt <= '0;
         end else if (fall) begin
            case (state)
               IDLE:    bit_cnt <= '0;
               DATA: begin
                  shift   <= {data_s, shift[7:1]};
                  bit_cnt <= bit_cnt + 3'd1;
               end
               PARITY:  par_bit <= data_s;
               default: ;
            endcase
         end
      end
   end

   // Decoder state and pulses share one register stage so outputs move with byte_valid.
   always_ff @(posedge clk) begin
      if (rst) begin
         byte_valid  <= 1'b0;
         frame_err   <= 1'b0;
         scan_code   <= '0;
         key_light   <= 1'b0;
         press_count <= '0;
         brk         <= 1'b0;
         ext         <= 1'b0;
      end else begin
         byte_valid <= accept;
         frame_err  <= reject | timeout;
         if (accept) begin
            if (shift == BREAK_CODE) begin
               brk <= 1'b1;
            end else if (shift == EXT_CODE) begin
               ext <= 1'b1;
            end else begin
               ext <= 1'b0;
               if (brk) begin
                  brk <= 1'b0;
                  if (shift == scan_code) key_light <= 1'b0;
               end else if (shift != scan_code || !key_light) begin
                  scan_code   <= shift;
                  key_light   <= 1'b1;
                  press_count <= press_count + 8'd1;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Self-checking bench for ps2_key_decoder: directed table, corner sequences, random frames.
module tb_ps2_key_decoder;
   localparam int TMO  = 100;
   localparam int SYNC = 2;
   localparam int HALF = 5;
`ifdef PS2_PARITY_CHECK_EN
   localparam bit PAR_CHK = 1'b1;
`else
   localparam bit PAR_CHK = 1'b0;
`endif

   typedef struct {
      logic [7:0] d;
      bit         bad_par;
      bit         bad_stop;
      logic [7:0] scan;
      bit         light;
      logic [7:0] cnt;
      int         bv;
      int         fe;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       ps2_clk = 1'b1;
   logic       ps2_data = 1'b1;
   logic [7:0] scan_code;
   logic       key_light;
   logic [7:0] press_count;
   logic       byte_valid;
   logic       frame_err;

   int checks = 0;
   int errors = 0;
   int bv_cnt = 0;
   int fe_cnt = 0;

   logic [7:0] m_scan;
   logic       m_light;
   logic [7:0] m_cnt;
   bit         m_brk;
   bit         m_ext;

   always #5 clk = ~clk;

   ps2_key_decoder #(.TIMEOUT_CYCLES(TMO), .SYNC_STAGES(SYNC)) dut (
      .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
      .scan_code(scan_code), .key_light(key_light), .press_count(press_count),
      .byte_valid(byte_valid), .frame_err(frame_err)
   );

   always @(negedge clk) begin
      if (byte_valid) bv_cnt++;
      if (frame_err)  fe_cnt++;
   end

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic send_bit(input logic b);
      @(negedge clk) ps2_data = b;
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit bad_stop);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(d[i]);
      send_bit((~^d) ^ bad_par);
      send_bit(!bad_stop);
      repeat (8) @(negedge clk);
      ps2_data = 1'b1;
   endtask

   task automatic do_reset(input int n);
      @(negedge clk) rst = 1'b1;
      repeat (n) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic check_outs(input string tag, input int s, input int l, input int c);
      check({tag, " scan_code"}, scan_code, s);
      check({tag, " key_light"}, key_light, l);
      check({tag, " press_count"}, press_count, c);
   endtask

   task automatic model_byte(input logic [7:0] d);
      if (d == 8'hF0) m_brk = 1'b1;
      else if (d == 8'hE0) m_ext = 1'b1;
      else begin
         m_ext = 1'b0;
         if (m_brk) begin
            m_brk = 1'b0;
            if (d == m_scan) m_light = 1'b0;
         end else if (d != m_scan || !m_light) begin
            m_scan  = d;
            m_light = 1'b1;
            m_cnt   = m_cnt + 8'd1;
         end
      end
   endtask

   initial begin
      vec_t       tbl[16];
      logic [7:0] pool[6];
      int         bv0, fe0, n;
      bit         seen;
      string      tag;

      tbl[0]  = '{8'h1C, 0, 0, 8'h1C, 1, 8'd1, 1, 0};
      tbl[1]  = '{8'h1C, 0, 0, 8'h1C, 1, 8'd1, 1, 0};
      tbl[2]  = '{8'h1C, 0, 0, 8'h1C, 1, 8'd1, 1, 0};
      tbl[3]  = '{8'hF0, 0, 0, 8'h1C, 1, 8'd1, 1, 0};
      tbl[4]  = '{8'h1C, 0, 0, 8'h1C, 0, 8'd1, 1, 0};
      tbl[5]  = '{8'h1C, 0, 0, 8'h1C, 1, 8'd2, 1, 0};
      tbl[6]  = '{8'h32, 0, 0, 8'h32, 1, 8'd3, 1, 0};
      tbl[7]  = '{8'hE0, 0, 0, 8'h32, 1, 8'd3, 1, 0};
      tbl[8]  = '{8'h75, 0, 0, 8'h75, 1, 8'd4, 1, 0};
      tbl[9]  = '{8'hF0, 0, 0, 8'h75, 1, 8'd4, 1, 0};
      tbl[10] = '{8'h32, 0, 0, 8'h75, 1, 8'd4, 1, 0};
      tbl[11] = '{8'h75, 0, 0, 8'h75, 1, 8'd4, 1, 0};
      tbl[12] = '{8'h1C, 0, 1, 8'h75, 1, 8'd4, 0, 1};
      tbl[13] = '{8'hF0, 0, 1, 8'h75, 1, 8'd4, 0, 1};
      tbl[14] = '{8'h75, 0, 0, 8'h75, 1, 8'd4, 1, 0};
      if (PAR_CHK) tbl[15] = '{8'h1C, 1, 0, 8'h75, 1, 8'd4, 0, 1};
      else         tbl[15] = '{8'h1C, 1, 0, 8'h1C, 1, 8'd5, 1, 0};
      pool = '{8'h1C, 8'h32, 8'h75, 8'hF0, 8'hE0, 8'h2A};

      // Reset state
      repeat (3) @(negedge clk);
      check_outs("reset", 0, 0, 0);
      check("reset byte_valid", byte_valid, 0);
      check("reset frame_err", frame_err, 0);
      rst = 1'b0;

      // Single make code, then reset held three cycles
      bv0 = bv_cnt;
      send_frame(8'h1C, 0, 0);
      check("first bv pulses", bv_cnt - bv0, 1);
      check_outs("first", 8'h1C, 1, 1);
      @(negedge clk) rst = 1'b1;
      @(negedge clk);
      check_outs("in reset", 0, 0, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check_outs("post reset", 0, 0, 0);

      // Directed table
      for (int i = 0; i < 16; i++) begin
         bv0 = bv_cnt;
         fe0 = fe_cnt;
         send_frame(tbl[i].d, tbl[i].bad_par, tbl[i].bad_stop);
         tag = $sformatf("tbl%0d", i);
         check({tag, " bv"}, bv_cnt - bv0, tbl[i].bv);
         check({tag, " fe"}, fe_cnt - fe0, tbl[i].fe);
         check_outs(tag, tbl[i].scan, tbl[i].light, tbl[i].cnt);
      end

      // Timeout: clock stops after 4 data bits
      bv0 = bv_cnt;
      fe0 = fe_cnt;
      send_bit(1'b0);
      for (int i = 0; i < 3; i++) send_bit(1'b1);
      @(negedge clk) ps2_data = 1'b0;
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b0;
      n = 0;
      seen = 1'b0;
      while (!seen && n < 1000) begin
         @(posedge clk);
         n++;
         @(negedge clk);
         if (n == HALF) ps2_clk = 1'b1;
         if (frame_err) seen = 1'b1;
      end
      ps2_clk  = 1'b1;
      ps2_data = 1'b1;
      check("timeout latency", seen ? n : -1, SYNC + TMO);
      repeat (5) @(negedge clk);
      check("timeout fe pulses", fe_cnt - fe0, 1);
      check("timeout bv pulses", bv_cnt - bv0, 0);
      send_frame(8'h2A, 0, 0);
      check("after timeout scan_code", scan_code, 8'h2A);
      check("after timeout key_light", key_light, 1);

      // Reset mid-frame: no error, next frame decoded from IDLE
      fe0 = fe_cnt;
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b0);
      do_reset(2);
      repeat (TMO + 20) @(negedge clk);
      check("midreset fe", fe_cnt - fe0, 0);
      check_outs("midreset", 0, 0, 0);
      bv0 = bv_cnt;
      send_bit(1'b1);
      repeat (20) @(negedge clk);
      check("idle high edge fe", fe_cnt - fe0, 0);
      check("idle high edge bv", bv_cnt - bv0, 0);
      send_frame(8'h32, 0, 0);
      check_outs("after midreset", 8'h32, 1, 1);

      // Random frames against the byte-level model
      do_reset(2);
      m_scan = 8'h00; m_light = 1'b0; m_cnt = 8'h00; m_brk = 1'b0; m_ext = 1'b0;
      for (int i = 0; i < 40; i++) begin
         logic [7:0] d;
         bit bp, bs, ok;
         d  = pool[$urandom_range(0, 5)];
         bp = ($urandom_range(0, 9) == 0);
         bs = ($urandom_range(0, 9) == 0);
         ok = !bs && !(bp && PAR_CHK);
         bv0 = bv_cnt;
         fe0 = fe_cnt;
         send_frame(d, bp, bs);
         if (ok) model_byte(d);
         tag = $sformatf("rnd%0d", i);
         check({tag, " bv"}, bv_cnt - bv0, ok ? 1 : 0);
         check({tag, " fe"}, fe_cnt - fe0, ok ? 0 : 1);
         check_outs(tag, m_scan, m_light, m_cnt);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #5000000;
      $display("FAIL global timeout: got running expected finished");
      $fatal(1, "bench time limit reached");
   end

endmodule

// File: doc/ps2_key_decoder.md
PS2_KEY_DECODER -- requirements
Module: ps2_key_decoder

Interface
REQ-001 The parameter list SHALL be: TIMEOUT_CYCLES, default 50000, idle clk cycles mid-frame before the frame is aborted.
REQ-002 The parameter list SHALL be: SYNC_STAGES, default 2, synchroniser flops on ps2_clk and ps2_data, minimum 2.
REQ-003 The port list SHALL include: clk  input  1  system clock; all logic on rising edge.
REQ-004 The port list SHALL include: rst  input  1  synchronous, active-high reset.
REQ-005 The port list SHALL include: ps2_clk  input  1  asynchronous PS/2 device clock.
REQ-006 The port list SHALL include: ps2_data  input  1  asynchronous PS/2 device data.
REQ-007 The port list SHALL include: scan_code  output  8  last accepted make code; feeds the two-digit hex display stage.
REQ-008 The port list SHALL include: key_light  output  1  high while the key in scan_code is held; feeds the display blanking input.
REQ-009 The port list SHALL include: press_count  output  8  count of new key presses, wraps 255->0.
REQ-010 The port list SHALL include: byte_valid  output  1  one-cycle pulse per accepted frame byte.
REQ-011 The port list SHALL include: frame_err  output  1  one-cycle pulse per rejected or aborted frame.

Function
REQ-012 ps2_clk and ps2_data SHALL pass through SYNC_STAGES flops, plus one history flop on the clock path; a falling edge is synced-previous=1 and synced-current=0.
REQ-013 Receive FSM states SHALL be IDLE, DATA, PARITY, STOP. Sampling SHALL occur only on a detected falling edge.
REQ-014 In IDLE, an edge with data=0 (start bit) SHALL go to DATA with bit counter 0. An edge with data=1 SHALL stay in IDLE with no error.
REQ-015 In DATA, each edge SHALL shift data in LSB first. After the 8th bit the FSM SHALL go to PARITY.
REQ-016 In PARITY, the bit SHALL be latched and the FSM SHALL go to STOP.
REQ-017 In STOP, an edge with data=1 and a valid frame SHALL accept the byte. data=0 SHALL reject it. Either way the FSM SHALL return to IDLE.
REQ-018 byte_valid or frame_err SHALL pulse exactly one cycle, in the cycle after the stop-bit edge is detected.
REQ-019 Outside IDLE, an idle counter SHALL reset on every edge. Reaching TIMEOUT_CYCLES SHALL force IDLE and pulse frame_err once.
REQ-020 Accepted byte 0xF0 SHALL set a break flag. 0xE0 SHALL set an extended flag. Neither SHALL change scan_code, key_light or press_count.
REQ-021 An accepted byte after the break flag SHALL clear both flags. If the byte equals scan_code, key_light SHALL be cleared. Otherwise it is ignored.
REQ-022 A make byte with no break flag that differs from scan_code, or arrives while key_light=0, SHALL load scan_code, set key_light and increment press_count, all in the same cycle.
REQ-023 A make byte equal to scan_code while key_light=1 (typematic repeat) SHALL change nothing.
REQ-024 The extended flag SHALL clear after any non-prefix byte. It is not reflected on outputs.
REQ-025 Decoder outputs SHALL update in the same cycle byte_valid is high.
REQ-026 A rejected frame SHALL leave the break and extended flags unchanged.

Reset
REQ-027 While rst=1 at a clk edge: FSM=IDLE, bit counter=0, idle counter=0, flags cleared, synchronisers=1.
REQ-028 While rst=1, outputs SHALL be: scan_code=0x00, key_light=0, press_count=0, byte_valid=0, frame_err=0.
REQ-029 Reset mid-frame SHALL discard the partial frame without a frame_err pulse.
REQ-030 The first edge after reset release SHALL be treated from IDLE.

Configuration
REQ-031 With macro PS2_PARITY_CHECK_EN defined, a frame whose 8 data bits plus parity bit hold an even count of ones SHALL be rejected with frame_err.
REQ-032 Without PS2_PARITY_CHECK_EN, the parity bit SHALL be sampled and ignored, and only the stop bit SHALL be checked.

Verification
REQ-033 Frame 0x1C with correct parity, then rst held 3 cycles -> byte_valid once, scan_code=0x1C, key_light=1, press_count=1; after reset all outputs=0.
REQ-034 Sequence 0x1C,0x1C,0x1C -> press_count stays 1, scan_code=0x1C, three byte_valid pulses.
REQ-035 Sequence 0x1C,0xF0,0x1C -> key_light=0 after the third byte_valid, scan_code stays 0x1C, press_count=1.
REQ-036 Sequence 0x1C,0x32 -> scan_code=0x32, key_light=1, press_count=2. Sequence 0xE0,0x75 -> scan_code=0x75.
REQ-037 Frame 0x1C with a wrong parity bit, macro defined -> frame_err pulse, outputs unchanged. Macro undefined -> accepted, scan_code=0x1C.
REQ-038 Stop ps2_clk after 4 data bits, TIMEOUT_CYCLES=100 -> frame_err pulses exactly 100 cycles after the last edge, FSM=IDLE. Next full frame 0x2A -> scan_code=0x2A.
